// File: rtl/iir_pkg.sv
// Shared types and constants for the biquad cascade: FSM states, coefficient
// slot indices, accumulator sizing and the power-on coefficient set.
package iir_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StMac,
    StWb,
    StOut
  } state_t;

  // Coefficient slot order inside one section.
  localparam int unsigned B0 = 0;
  localparam int unsigned B1 = 1;
  localparam int unsigned B2 = 2;
  localparam int unsigned A1 = 3;
  localparam int unsigned A2 = 4;
  localparam int unsigned NUM_TAPS = 5;

  // Three guard bits cover the sum of five full-precision products.
  function automatic int unsigned acc_width(input int unsigned data_w, input int unsigned coef_w);
    return data_w + coef_w + 3;
  endfunction

  // Passthrough: b0 = 1.0, everything else 0.
  function automatic int default_coef(input int unsigned k, input int unsigned frac);
    return (k == B0) ? (1 << frac) : 0;
  endfunction

endpackage

// File: rtl/iir_mac_unit.sv
// Single shared multiply-accumulate with round-half-up and saturation of the
// accumulator down to a DATA_W sample.
module iir_mac_unit #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned COEF_W = 16,
  parameter int unsigned FRAC   = 14,
  parameter int unsigned ACC_W  = 35
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     en,
  input  logic                     sub,
  input  logic signed [COEF_W-1:0] coef,
  input  logic signed [DATA_W-1:0] data,
  output logic signed [DATA_W-1:0] y,
  output logic                     sat
);

  localparam int unsigned ProdW = DATA_W + COEF_W;
  localparam logic signed [ACC_W-1:0] Half = ACC_W'(1) << (FRAC - 1);
  localparam logic signed [ACC_W-1:0] YMax = (ACC_W'(1) << (DATA_W - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] YMin = -(ACC_W'(1) << (DATA_W - 1));

  logic signed [ProdW-1:0] prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] rnd;
  logic signed [ACC_W-1:0] shifted;

  assign prod     = coef * data;
  assign prod_ext = {{(ACC_W - ProdW){prod[ProdW-1]}}, prod};
  assign rnd      = acc_q + Half;
  assign shifted  = rnd >>> FRAC;

  // Accumulator: cleared between sections, adds feed-forward, subtracts feedback.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else if (clr) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= sub ? (acc_q - prod_ext) : (acc_q + prod_ext);
    end
  end

  // Clamp the rounded result into the signed sample range.
  always_comb begin
    y   = shifted[DATA_W-1:0];
    sat = 1'b0;
    if (shifted > YMax) begin
      y   = YMax[DATA_W-1:0];
      sat = 1'b1;
    end else if (shifted < YMin) begin
      y   = YMin[DATA_W-1:0];
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/iir_sos_cascade.sv
// Cascade of Direct-Form-I biquads sharing one MAC. Each section takes five
// MAC cycles and one writeback cycle; coefficients and flush act only in idle.
module iir_sos_cascade
  import iir_pkg::*;
#(
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned COEF_W       = 16,
  parameter int unsigned FRAC         = 14,
  parameter int unsigned NUM_SECTIONS = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic signed [DATA_W-1:0]              in_data,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  output logic signed [DATA_W-1:0]              out_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic                                  out_sat,
  input  logic                                  coef_we,
  input  logic [$clog2(5*NUM_SECTIONS)-1:0]     coef_addr,
  input  logic signed [COEF_W-1:0]              coef_wdata,
  input  logic                                  flush
);

  localparam int unsigned NumCoef = NUM_TAPS * NUM_SECTIONS;
  localparam int unsigned AddrW   = $clog2(NumCoef);
  localparam int unsigned SecW    = (NUM_SECTIONS > 1) ? $clog2(NUM_SECTIONS) : 1;
  localparam int unsigned AccW    = acc_width(DATA_W, COEF_W);

  state_t state_q, state_d;

  logic [SecW-1:0]          s_q;
  logic [2:0]               k_q;
  logic signed [DATA_W-1:0] x_cur_q;
  logic                     sat_q;
  logic signed [DATA_W-1:0] out_data_q;
  logic                     out_sat_q;

  logic signed [COEF_W-1:0] coef_q [NumCoef];
  logic signed [DATA_W-1:0] x1_q   [NUM_SECTIONS];
  logic signed [DATA_W-1:0] x2_q   [NUM_SECTIONS];
  logic signed [DATA_W-1:0] y1_q   [NUM_SECTIONS];
  logic signed [DATA_W-1:0] y2_q   [NUM_SECTIONS];

  logic [AddrW-1:0]         coef_idx;
  logic signed [COEF_W-1:0] mac_coef;
  logic signed [DATA_W-1:0] mac_data;
  logic                     mac_clr;
  logic                     mac_en;
  logic                     mac_sub;
  logic signed [DATA_W-1:0] sec_y;
  logic                     sec_sat;
  logic                     last_sec;

  assign coef_idx = AddrW'(s_q) * AddrW'(NUM_TAPS) + AddrW'(k_q);
  assign mac_coef = coef_q[coef_idx];
  assign mac_en   = (state_q == StMac);
  assign mac_clr  = (state_q != StMac);
  assign mac_sub  = (k_q >= 3'(A1));
  assign last_sec = (s_q == SecW'(NUM_SECTIONS - 1));

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StOut);
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

  // Select the MAC operand for the current tap of the current section.
  always_comb begin
    mac_data = x_cur_q;
    case (k_q)
      3'(B1):  mac_data = x1_q[s_q];
      3'(B2):  mac_data = x2_q[s_q];
      3'(A1):  mac_data = y1_q[s_q];
      3'(A2):  mac_data = y2_q[s_q];
      default: mac_data = x_cur_q;
    endcase
  end

  iir_mac_unit #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .FRAC   (FRAC),
    .ACC_W  (AccW)
  ) u_mac (
    .clk  (clk),
    .rst  (rst),
    .clr  (mac_clr),
    .en   (mac_en),
    .sub  (mac_sub),
    .coef (mac_coef),
    .data (mac_data),
    .y    (sec_y),
    .sat  (sec_sat)
  );

  // Sequencer next-state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (in_valid) state_d = StMac;
      StMac:  if (k_q == 3'(A2)) state_d = StWb;
      StWb:   state_d = last_sec ? StOut : StMac;
      StOut:  if (out_ready) state_d = StIdle;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Counters, coefficient file, delay lines and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q        <= '0;
      k_q        <= '0;
      x_cur_q    <= '0;
      sat_q      <= 1'b0;
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
      for (int unsigned i = 0; i < NumCoef; i++) begin
        coef_q[i] <= COEF_W'(default_coef(i % NUM_TAPS, FRAC));
      end
      for (int unsigned i = 0; i < NUM_SECTIONS; i++) begin
        x1_q[i] <= '0;
        x2_q[i] <= '0;
        y1_q[i] <= '0;
        y2_q[i] <= '0;
      end
    end else begin
      case (state_q)
        StIdle: begin
          if (flush) begin
            for (int unsigned i = 0; i < NUM_SECTIONS; i++) begin
              x1_q[i] <= '0;
              x2_q[i] <= '0;
              y1_q[i] <= '0;
              y2_q[i] <= '0;
            end
          end
          if (coef_we && (32'(coef_addr) < NumCoef)) begin
            coef_q[coef_addr] <= coef_wdata;
          end
          if (in_valid) begin
            x_cur_q <= in_data;
            sat_q   <= 1'b0;
            s_q     <= '0;
            k_q     <= '0;
          end
        end
        StMac: begin
          k_q <= (k_q == 3'(A2)) ? 3'd0 : k_q + 3'd1;
        end
        StWb: begin
          x2_q[s_q] <= x1_q[s_q];
          x1_q[s_q] <= x_cur_q;
          y2_q[s_q] <= y1_q[s_q];
          y1_q[s_q] <= sec_y;
          sat_q     <= sat_q | sec_sat;
          if (!last_sec) begin
            s_q     <= s_q + 1'b1;
            x_cur_q <= sec_y;
          end else begin
            out_data_q <= sec_y;
            out_sat_q  <= sat_q | sec_sat;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/iir_sos_cascade.md
# iir_sos_cascade

Parametrised IIR filter built as a cascade of `NUM_SECTIONS` Direct-Form-I second-order sections (biquads). It uses one time-multiplexed multiply-accumulate unit, runtime-writable coefficients, round-half-up quantisation and saturation. It is the successor to the fixed-order, file-initialised IIR: it adds valid/ready streaming handshakes, order scaling through section count, and a coefficient write port. It sits between the sample source and the downstream stage of the filtering datapath.

## Interface
- `DATA_W`, 16: signed sample width, in and out.
- `COEF_W`, 16: signed coefficient width.
- `FRAC`, 14: coefficient fractional bits (Q(COEF_W-FRAC).FRAC).
- `NUM_SECTIONS`, 2: number of cascaded biquads, 1..16.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `in_data` in DATA_W: signed input sample.
- `in_valid` in 1: input sample valid.
- `in_ready` out 1: block can accept a sample.
- `out_data` out DATA_W: signed filtered sample.
- `out_valid` out 1: output sample valid.
- `out_ready` in 1: downstream accepts the output.
- `out_sat` out 1: qualified by `out_valid`; high if any section saturated for this sample.
- `coef_we` in 1: coefficient write strobe.
- `coef_addr` in clog2(5·NUM_SECTIONS): address = section·5 + k, with k = 0..4 for b0, b1, b2, a1, a2.
- `coef_wdata` in COEF_W: coefficient value.
- `flush` in 1: clear all delay lines. Honoured only in IDLE.

## Operation
- Per section s, with x = section input: acc = b0·x + b1·x1 + b2·x2 − a1·y1 − a2·y2.
  - a0 is implied 1.0.
  - Section 0 input is `in_data`. Section s>0 input is section s−1's quantised output.
- Accumulator width is DATA_W+COEF_W+3, signed. Products are full precision, with no intermediate truncation.
- Quantisation: y = sat((acc + 2^(FRAC−1)) >>> FRAC) to the DATA_W signed range.
  - Saturated values are stored in y1 and forwarded to the next section.
  - Any clamp sets the per-sample saturation flag.
- The delay update per section after writeback is x2←x1, x1←x, y2←y1, y1←y.
- FSM states:
  - IDLE: `in_ready`=1. On `in_valid` it latches the sample, clears the sat flag, sets s=0, k=0 and goes to MAC.
  - MAC: one product per cycle, k=0..4, accumulated. After k=4 it goes to WB.
  - WB: quantise and update the delay lines for s. If s<NUM_SECTIONS−1 it sets s+1, clears acc and returns to MAC. Otherwise it registers `out_data`/`out_sat` and goes to OUT.
  - OUT: `out_valid`=1. On `out_ready` it goes to IDLE.
- Coefficient writes:
  - Applied only in IDLE.
  - Writes in any other state, and writes with addr ≥ 5·NUM_SECTIONS, are silently dropped.
- `flush` in IDLE zeroes every x1/x2/y1/y2 in the same edge. Coefficients are untouched.
- When `flush` and `in_valid` are both asserted in IDLE, the flush applies first and the sample is accepted and computed with zero history.
- Reset values:
  - `out_data`=0, `out_valid`=0, `out_sat`=0, `in_ready`=1 (IDLE).
  - All delay lines are 0.
  - Coefficients are b0=2^FRAC (1.0) and all others 0, i.e. passthrough.
- Reset mid-operation aborts the sample with no output, restores all reset values and discards the written coefficients.

## Timing
- Sample accepted at edge T (`in_valid`&&`in_ready`). `out_valid` is high from edge T+6·NUM_SECTIONS.
- Each section takes 5 MAC cycles plus 1 WB cycle.
- `in_ready` is low from T until the edge after the `out_valid`&&`out_ready` handshake.
- Minimum sample period is 6·NUM_SECTIONS+1 cycles.
- `out_data` and `out_sat` are held stable while `out_valid`=1 and `out_ready`=0.
- `in_ready` and `out_valid` are registered, never combinationally dependent on inputs.
- A coefficient written at edge E is used by any sample accepted at an edge ≥ E+1.

## Structure
- Package `iir_pkg`:
  - FSM state enum (IDLE, MAC, WB, OUT).
  - Coefficient index constants B0..A2 = 0..4.
  - ACC_W derivation.
  - Default-coefficient function.
- Sub-module `iir_mac_unit`: one signed multiplier, accumulator clear/add/subtract, and the round/saturate stage producing y and a sat flag.
- The top module holds the FSM, counters s/k, the coefficient and delay register files, and the handshakes.

## Test plan
All tests use DATA_W=16, COEF_W=16, FRAC=14, NUM_SECTIONS=2.
1. Reset passthrough: after reset, input 1000 → `out_data`=1000, `out_sat`=0, `out_valid` exactly 12 edges after acceptance.
2. FIR taps: s0 b0=8192, b1=4096, rest 0. Inputs 16384, 0, 0 → outputs 8192, 4096, 0.
3. Feedback: s0 a1=−8192. Inputs 1000, 0, 0, 0 → 1000, 500, 250, 125. Then `flush` plus input 0 → 0.
4. Saturation: b0=32767 in both sections. Input 32767 → 32767 with `out_sat`=1. Input −32768 → −32768 with `out_sat`=1.
5. Backpressure and write lockout: hold `out_ready`=0 for 10 cycles.
   - `out_data` and `out_valid` stay stable and `in_ready`=0.
   - A `coef_we` in this window is dropped; the next sample still uses the old coefficients.
6. Reset mid-MAC: assert `rst` in cycle 3 of a sample → no `out_valid`, `in_ready`=1 after release, coefficients back to passthrough, next input 77 → 77.
